// File: rtl/sevenseg_595_driver.sv
// sevenseg_595_driver
//   Takes a 32-bit word over a valid/ready handshake and encodes it as eight
//   hex digits for 7-segment display. The resulting 64-bit segment frame is
//   shifted into a chain of eight 74HC595 registers, digit 7 first and MSB
//   (decimal point) first. The storage latch is then pulsed.
//
// Parameters
//   CLK_DIV        clk_i cycles per SRCLK half-period (>= 1)
//   SEG_ACTIVE_LOW 1 inverts every frame bit (common-anode displays)
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   data_i[31:0], dp_i[7:0] digit k = data_i[4k+3:4k], decimal point dp_i[k]
//   valid_i / ready_o      input handshake; ready_o high only in IDLE
//   blank_i                1 disables the display outputs (OE)
//   sr_ser_o, sr_srclk_o, sr_rclk_o, sr_oe_n_o  74HC595 chain controls
//   busy_o                 frame in progress
//   done_o                 one-cycle pulse when the latch sequence completes
module sevenseg_595_driver #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_i,
  input  logic [7:0]  dp_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        blank_i,
  output logic        sr_ser_o,
  output logic        sr_srclk_o,
  output logic        sr_rclk_o,
  output logic        sr_oe_n_o,
  output logic        busy_o,
  output logic        done_o
);

  if (CLK_DIV == 0) begin : g_bad_clk_div
    $error("sevenseg_595_driver: CLK_DIV must be >= 1");
  end

  localparam int unsigned    DW       = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [7:0]     POL      = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH_HI,
    S_LATCH_LO,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_div;
  logic [6:0]    r_bitcnt;
  logic [31:0]   r_data;
  logic [7:0]    r_dp;
  // Holds the bits still to be sent after the one currently on r_ser.
  logic [63:0]   r_frame;
  logic          r_ser;
  logic          r_srclk;
  logic          r_rclk;
  logic          r_oe_n;
  logic          r_latched;
  logic          r_done;

  logic          w_div_end;
  logic          w_latch_end;
  logic [63:0]   w_frame;

  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Digit k occupies frame bits [8k+7:8k], so digit 7 / dp leads the stream.
  always_comb begin
    w_frame = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      w_frame[8*k +: 8] = {r_dp[k], f_seg(r_data[4*k +: 4])} ^ POL;
    end
  end

  assign w_div_end   = (r_div == DIV_LAST);
  assign w_latch_end = (r_state == S_LATCH_HI) && w_div_end;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_bitcnt  <= '0;
      r_data    <= '0;
      r_dp      <= '0;
      r_frame   <= '0;
      r_ser     <= 1'b0;
      r_srclk   <= 1'b0;
      r_rclk    <= 1'b0;
      r_oe_n    <= 1'b1;
      r_latched <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // OE is released on the same edge that ends the first latch high phase.
      r_oe_n <= (r_latched || w_latch_end) ? blank_i : 1'b1;
      if (w_latch_end) begin
        r_latched <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_data  <= data_i;
            r_dp    <= dp_i;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_ser    <= w_frame[63];
          r_frame  <= {w_frame[62:0], 1'b0};
          r_bitcnt <= '0;
          r_div    <= '0;
          r_state  <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_srclk <= 1'b1;
            r_state <= S_SHIFT_HI;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_SHIFT_HI: begin
          if (w_div_end) begin
            r_div    <= '0;
            r_srclk  <= 1'b0;
            r_bitcnt <= r_bitcnt + 7'd1;
            if (r_bitcnt == 7'd63) begin
              r_rclk  <= 1'b1;
              r_state <= S_LATCH_HI;
            end else begin
              r_ser   <= r_frame[63];
              r_frame <= {r_frame[62:0], 1'b0};
              r_state <= S_SHIFT_LO;
            end
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_LATCH_HI: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_rclk  <= 1'b0;
            r_state <= S_LATCH_LO;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_LATCH_LO: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_done  <= 1'b1;
            r_ser   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = (r_state == S_IDLE);
  assign busy_o     = (r_state != S_IDLE);
  assign sr_ser_o   = r_ser;
  assign sr_srclk_o = r_srclk;
  assign sr_rclk_o  = r_rclk;
  assign sr_oe_n_o  = r_oe_n;
  assign done_o     = r_done;

endmodule

// File: tb/tb_sevenseg_595_driver.sv
// Testbench for sevenseg_595_driver: one instance with CLK_DIV=2 (active-high
// segments) and one with CLK_DIV=1 (active-low segments), checked against a
// frame model built from the hex table and the digit/bit ordering rules.
module tb_sevenseg_595_driver;

  localparam int unsigned DA = 2;
  localparam int unsigned DB = 1;

  localparam logic [7:0] HEX7 [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] data_a, data_b;
  logic [7:0]  dp_a, dp_b;
  logic valid_a, valid_b, blank_a, blank_b;
  logic ready_a, ser_a, srclk_a, rclk_a, oen_a, busy_a, done_a;
  logic ready_b, ser_b, srclk_b, rclk_b, oen_b, busy_b, done_b;

  sevenseg_595_driver #(.CLK_DIV(DA), .SEG_ACTIVE_LOW(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_a), .dp_i(dp_a), .valid_i(valid_a),
    .ready_o(ready_a), .blank_i(blank_a), .sr_ser_o(ser_a), .sr_srclk_o(srclk_a),
    .sr_rclk_o(rclk_a), .sr_oe_n_o(oen_a), .busy_o(busy_a), .done_o(done_a));

  sevenseg_595_driver #(.CLK_DIV(DB), .SEG_ACTIVE_LOW(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_b), .dp_i(dp_b), .valid_i(valid_b),
    .ready_o(ready_b), .blank_i(blank_b), .sr_ser_o(ser_b), .sr_srclk_o(srclk_b),
    .sr_rclk_o(rclk_b), .sr_oe_n_o(oen_b), .busy_o(busy_b), .done_o(done_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Per-instance observation state (index 0 = dut_a, 1 = dut_b).
  int          rises [2];
  int          rclk_hi [2];
  int          rclk_rise [2];
  int          done_cnt [2];
  int          done_cyc [2];
  logic [63:0] shreg [2];
  logic        p_srclk [2];
  logic        p_rclk [2];
  bit          en [2];
  int          acc_a, acc_b;

  function automatic logic [63:0] model(input logic [31:0] d, input logic [7:0] dp, input bit al);
    logic [63:0] f = '0;
    int unsigned nib;
    logic [7:0]  b;
    for (int k = 7; k >= 0; k--) begin
      nib = (d >> (4 * k)) & 32'hF;
      b   = HEX7[nib] + (dp[k] ? 8'h80 : 8'h00);
      if (al) b = 8'hFF - b;
      f = (f << 8) | 64'(b);
    end
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int i, input logic ser, input logic srclk, input logic rclk,
                        input logic oen, input logic done, input logic blk);
    if (srclk && !p_srclk[i]) begin
      rises[i]++;
      shreg[i] = {shreg[i][62:0], ser};
    end
    if (rclk) rclk_hi[i]++;
    if (rclk && !p_rclk[i]) rclk_rise[i]++;
    if (!rclk && p_rclk[i]) en[i] = 1'b1;
    if (done) begin
      done_cnt[i]++;
      done_cyc[i] = cyc;
    end
    chk((i == 0) ? "a_oe_n" : "b_oe_n", oen, en[i] ? blk : 1'b1);
    p_srclk[i] = srclk;
    p_rclk[i]  = rclk;
  endtask

  task automatic tick();
    logic ba, bb;
    ba = blank_a;
    bb = blank_b;
    @(posedge clk);
    #1;
    cyc++;
    sample(0, ser_a, srclk_a, rclk_a, oen_a, done_a, ba);
    sample(1, ser_b, srclk_b, rclk_b, oen_b, done_b, bb);
  endtask

  task automatic clear_mon(input int i);
    rises[i] = 0; rclk_hi[i] = 0; rclk_rise[i] = 0; done_cnt[i] = 0; shreg[i] = '0;
  endtask

  task automatic go_a(input logic [31:0] d, input logic [7:0] dp, input bit hold);
    for (int n = 0; n < 1000 && !ready_a; n++) tick();
    data_a = d; dp_a = dp; valid_a = 1'b1;
    clear_mon(0);
    tick();
    acc_a = cyc;
    chk("a_accept_busy", busy_a, 1'b1);
    if (!hold) valid_a = 1'b0;
  endtask

  task automatic go_b(input logic [31:0] d, input logic [7:0] dp);
    for (int n = 0; n < 1000 && !ready_b; n++) tick();
    data_b = d; dp_b = dp; valid_b = 1'b1;
    clear_mon(1);
    tick();
    acc_b = cyc;
    chk("b_accept_busy", busy_b, 1'b1);
    valid_b = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input bit rand_blank);
    int n = 0;
    while (done_cnt[i] == 0 && n < budget) begin
      if (rand_blank && $urandom_range(0, 3) == 0) blank_a = ~blank_a;
      tick();
      n++;
    end
    chk((i == 0) ? "a_done_timeout" : "b_done_timeout", done_cnt[i] != 0, 1'b1);
  endtask

  task automatic check_frame(input int i, input logic [63:0] expf, input int d, input int acc,
                             input string pre);
    chk({pre, "frame"}, shreg[i], expf);
    chk({pre, "srclk_rises"}, rises[i], 64);
    chk({pre, "rclk_width"}, rclk_hi[i], d);
    chk({pre, "rclk_pulses"}, rclk_rise[i], 1);
    chk({pre, "done_pulses"}, done_cnt[i], 1);
    chk({pre, "done_latency"}, done_cyc[i] - acc + 1, 1 + 128 * d + 2 * d + 1);
  endtask

  initial begin
    logic [31:0] x, y;
    logic [7:0]  dpx;
    int          prev_done;

    rst_n = 1'b0;
    data_a = '0; dp_a = '0; valid_a = 1'b0; blank_a = 1'b0;
    data_b = '0; dp_b = '0; valid_b = 1'b0; blank_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      p_srclk[i] = 1'b0; p_rclk[i] = 1'b0; en[i] = 1'b0; done_cyc[i] = 0;
      clear_mon(i);
    end

    // Reset held while valid toggles.
    for (int n = 0; n < 4; n++) begin
      valid_a = ~valid_a;
      valid_b = ~valid_b;
      data_a  = $urandom;
      tick();
      chk("rst_ready", ready_a, 1'b1);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_ser", ser_a, 1'b0);
      chk("rst_srclk", srclk_a, 1'b0);
      chk("rst_rclk", rclk_a, 1'b0);
      chk("rst_done", done_a, 1'b0);
      chk("rst_ready_b", ready_b, 1'b1);
    end
    chk("rst_no_srclk", rises[0] + rises[1], 0);
    valid_a = 1'b0; valid_b = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // Basic frame.
    go_a(32'h01234567, 8'h00, 1'b0);
    wait_done(0, 2000, 1'b0);
    tick();
    check_frame(0, model(32'h01234567, 8'h00, 1'b0), DA, acc_a, "basic_");
    tick();
    chk("basic_oe_on", oen_a, 1'b0);

    // Active-low with decimal point on digit 7.
    go_b(32'hFFFFFFFF, 8'h80);
    wait_done(1, 1000, 1'b0);
    tick();
    check_frame(1, model(32'hFFFFFFFF, 8'h80, 1'b1), DB, acc_b, "al_");

    // valid held, data changed mid-frame.
    x = $urandom; y = $urandom; dpx = 8'($urandom);
    go_a(x, dpx, 1'b1);
    for (int n = 0; n < 30; n++) tick();
    data_a = y; dp_a = ~dpx;
    wait_done(0, 2000, 1'b0);
    prev_done = done_cyc[0];
    tick();
    chk("busy_ready_after_done", ready_a, 1'b1);
    check_frame(0, model(x, dpx, 1'b0), DA, acc_a, "busy1_");
    clear_mon(0);
    tick();
    chk("busy_reaccept", busy_a, 1'b1);
    chk("busy_gap", cyc - prev_done, 2);
    acc_a = cyc;
    valid_a = 1'b0;
    wait_done(0, 2000, 1'b0);
    tick();
    check_frame(0, model(y, ~dpx, 1'b0), DA, acc_a, "busy2_");

    // Reset after the 20th SRCLK rise.
    go_a($urandom, 8'($urandom), 1'b0);
    for (int n = 0; n < 1000 && rises[0] < 20; n++) tick();
    chk("mid_rises", rises[0], 20);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", ready_a, 1'b1);
    chk("mid_busy", busy_a, 1'b0);
    chk("mid_ser", ser_a, 1'b0);
    chk("mid_srclk", srclk_a, 1'b0);
    chk("mid_rclk", rclk_a, 1'b0);
    chk("mid_oe_n", oen_a, 1'b1);
    chk("mid_done", done_a, 1'b0);
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; p_srclk[i] = 1'b0; p_rclk[i] = 1'b0;
    end
    for (int n = 0; n < 3; n++) tick();
    rst_n = 1'b1;
    tick();
    chk("mid_no_rclk", rclk_rise[0], 0);
    chk("mid_oe_still_off", oen_a, 1'b1);
    go_a(32'h89ABCDEF, 8'h00, 1'b0);
    wait_done(0, 2000, 1'b0);
    tick();
    check_frame(0, model(32'h89ABCDEF, 8'h00, 1'b0), DA, acc_a, "after_rst_");

    // Random frames with blank_i toggling throughout.
    for (int r = 0; r < 3; r++) begin
      x = $urandom; dpx = 8'($urandom);
      go_a(x, dpx, 1'b0);
      wait_done(0, 2000, 1'b1);
      tick();
      check_frame(0, model(x, dpx, 1'b0), DA, acc_a, "rnd_a_");
    end
    blank_a = 1'b1;
    tick();
    chk("blank_off", oen_a, 1'b1);
    blank_a = 1'b0;
    tick();
    chk("blank_on", oen_a, 1'b0);

    for (int r = 0; r < 3; r++) begin
      x = $urandom; dpx = 8'($urandom);
      go_b(x, dpx);
      wait_done(1, 1000, 1'b0);
      tick();
      check_frame(1, model(x, dpx, 1'b1), DB, acc_b, "rnd_b_");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
